// File: rtl/mtncl_sync_tx.sv
// mtncl_sync_tx: synchronous-to-MTNCL transmitter.
// Buffers single-rail words in a small FIFO and drives each one onto a
// dual-rail bus as a DATA wavefront, then returns the bus to NULL. Each
// phase change is paced by the downstream completion signal ko.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   in_data/valid    - word input; in_ready = FIFO not full
//   ko               - downstream completion (async): 1 = want DATA, 0 = want NULL
//   rail1/rail0      - dual-rail true/false rails
//   sleep            - MTNCL sleep to first stage (1 forces NULL)
//   busy             - FSM not IDLE or FIFO not empty
//   err              - sticky handshake timeout
//   sent_cnt         - completed DATA+NULL cycles, wraps at 2^16
module mtncl_sync_tx #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ko,
  output logic [WIDTH-1:0] rail1,
  output logic [WIDTH-1:0] rail0,
  output logic             sleep,
  output logic             busy,
  output logic             err,
  output logic [15:0]      sent_cnt
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMO_W = 8;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_NULL_WAIT = 2'd0,
    S_IDLE      = 2'd1,
    S_DATA_WAIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               ko_meta_q, ko_s_q;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   rail1_q, rail1_d, rail0_q, rail0_d;
  logic               sleep_q, sleep_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d, tmo_inc;
  logic               err_q, err_d;
  logic [15:0]        sent_q, sent_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               push, pop;

  // Next-state, bus, FIFO and timeout logic.
  always_comb begin
    push     = in_valid && in_ready_q;
    pop      = 1'b0;
    state_d  = state_q;
    rail1_d  = rail1_q;
    rail0_d  = rail0_q;
    sleep_d  = sleep_q;
    sent_d   = sent_q;
    tmo_inc  = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
    tmo_d    = tmo_q;

    case (state_q)
      S_NULL_WAIT: begin
        tmo_d = tmo_inc;
        if (ko_s_q) begin
          state_d = S_IDLE;
          tmo_d   = '0;
        end
      end
      S_IDLE: begin
        tmo_d = '0;
        if ((count_q != '0) && ko_s_q) begin
          rail1_d = mem_q[rd_ptr_q];
          rail0_d = ~mem_q[rd_ptr_q];
          sleep_d = 1'b0;
          pop     = 1'b1;
          state_d = S_DATA_WAIT;
        end
      end
      S_DATA_WAIT: begin
        tmo_d = tmo_inc;
        if (!ko_s_q) begin
          rail1_d = '0;
          rail0_d = '0;
          sleep_d = 1'b1;
          sent_d  = sent_q + 16'd1;
          state_d = S_NULL_WAIT;
          tmo_d   = '0;
        end
      end
      default: begin
        rail1_d = '0;
        rail0_d = '0;
        sleep_d = 1'b1;
        state_d = S_NULL_WAIT;
        tmo_d   = '0;
      end
    endcase

    // Only a wait state can accumulate toward the timeout.
    err_d = err_q || ((state_d != S_IDLE) && (tmo_d == TMO_MAX));

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Status flags are registered from next-state so they track without lag.
    in_ready_d = (count_d != FULL_CNT);
    busy_d     = (state_d != S_IDLE) || (count_d != '0);
  end

  // State, synchronizer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_NULL_WAIT;
      ko_meta_q  <= 1'b0;
      ko_s_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rail1_q    <= '0;
      rail0_q    <= '0;
      sleep_q    <= 1'b1;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      sent_q     <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      ko_meta_q  <= ko;
      ko_s_q     <= ko_meta_q;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rail1_q    <= rail1_d;
      rail0_q    <= rail0_d;
      sleep_q    <= sleep_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      sent_q     <= sent_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  // FIFO storage; contents are don't-care once pointers reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ready = in_ready_q;
  assign rail1    = rail1_q;
  assign rail0    = rail0_q;
  assign sleep    = sleep_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign sent_cnt = sent_q;

endmodule

// File: tb/tb_mtncl_sync_tx.sv
// Directed bench for mtncl_sync_tx; downstream ko is modelled by the tasks.
module tb_mtncl_sync_tx;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        ko;
  logic [7:0]  rail1, rail0;
  logic        sleep, busy, err;
  logic [15:0] sent_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_sent = 16'd0;
  logic        pend = 1'b0;
  logic        armed = 1'b0;

  mtncl_sync_tx #(.WIDTH(8), .DEPTH(4), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ko(ko), .rail1(rail1), .rail0(rail0),
    .sleep(sleep), .busy(busy), .err(err), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  // Rail exclusivity on every cycle.
  always @(negedge clk) begin
    checks++;
    if ((rail1 & rail0) !== 8'h00) begin
      errors++;
      $display("FAIL rail_invariant: rail1&rail0=%h required 00", rail1 & rail0);
    end
  end

  // One cycle; releases a held-off word once it has been accepted.
  task automatic tick();
    @(negedge clk);
    if (pend) begin
      if (armed) begin
        in_valid = 1'b0; pend = 1'b0; armed = 1'b0;
      end else if (in_ready) begin
        armed = 1'b1;
      end
    end
  endtask

  // Send one word from IDLE with ko_s=1; checks exact latencies.
  task automatic do_word(input logic [7:0] d);
    @(negedge clk); in_data = d; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    checks++;
    if (sleep !== 1'b1) begin errors++; $display("FAIL data_early: sleep=%b required 1", sleep); end
    @(negedge clk);
    checks++;
    if (sleep !== 1'b0 || rail1 !== d || rail0 !== ~d) begin
      errors++;
      $display("FAIL data_word: sleep=%b rail1=%h rail0=%h required 0 %h %h", sleep, rail1, rail0, d, ~d);
    end
    @(negedge clk); @(negedge clk); ko = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (sleep !== 1'b0) begin errors++; $display("FAIL data_hold: sleep=%b required 0", sleep); end
    @(negedge clk);
    exp_sent = exp_sent + 16'd1;
    checks++;
    if (sleep !== 1'b1 || rail1 !== 8'h00 || rail0 !== 8'h00) begin
      errors++;
      $display("FAIL null_word: sleep=%b rail1=%h rail0=%h required 1 00 00", sleep, rail1, rail0);
    end
    checks++;
    if (sent_cnt !== exp_sent) begin errors++; $display("FAIL sent_cnt: got %h required %h", sent_cnt, exp_sent); end
    @(negedge clk); @(negedge clk); ko = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ko = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (rail1 !== 8'h00 || rail0 !== 8'h00 || sleep !== 1'b1 || err !== 1'b0 ||
        sent_cnt !== 16'h0000 || busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: r1=%h r0=%h sleep=%b err=%b cnt=%h busy=%b rdy=%b required 00 00 1 0 0000 1 1",
               rail1, rail0, sleep, err, sent_cnt, busy, in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_c1: got %b required 1", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_c2: got %b required 1", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sleep !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_reached: busy=%b sleep=%b rdy=%b required 0 1 1", busy, sleep, in_ready);
    end
  endtask

  task automatic test_single();
    do_word(8'hA5);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    logic       got;
    ko = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== ((i < 4) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b required %b", i, in_ready, (i < 4) ? 1'b1 : 1'b0);
      end
      in_data = 8'(i + 1); in_valid = 1'b1;
    end
    pend = 1'b1; armed = 1'b0;
    repeat (3) tick();
    checks++;
    if (in_ready !== 1'b0 || sleep !== 1'b1) begin
      errors++;
      $display("FAIL b2b_full: rdy=%b sleep=%b required 0 1", in_ready, sleep);
    end
    ko = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp = 8'(k + 1);
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin tick(); if (sleep === 1'b0) got = 1'b1; end
      checks++;
      if (!got) begin
        errors++; $display("FAIL b2b_data_timeout[%0d]: sleep=%b required 0", k, sleep);
      end else if (rail1 !== exp || rail0 !== ~exp) begin
        errors++; $display("FAIL b2b_order[%0d]: rail1=%h rail0=%h required %h %h", k, rail1, rail0, exp, ~exp);
      end
      tick(); tick(); ko = 1'b0;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin tick(); if (sleep === 1'b1) got = 1'b1; end
      checks++;
      if (!got) begin errors++; $display("FAIL b2b_null_timeout[%0d]: sleep=%b required 1", k, sleep); end
      exp_sent = exp_sent + 16'd1;
      tick(); tick(); ko = 1'b1;
    end
    repeat (3) tick();
    checks++;
    if (sent_cnt !== exp_sent || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: cnt=%h busy=%b required %h 0", sent_cnt, busy, exp_sent);
    end
  endtask

  task automatic test_timeout();
    @(negedge clk); in_data = 8'h96; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (sleep !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL tmo_entry: sleep=%b err=%b required 0 0", sleep, err);
    end
    repeat (9) @(negedge clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL tmo_early: err=%b required 0", err); end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || sleep !== 1'b0 || rail1 !== 8'h96 || rail0 !== 8'h69) begin
      errors++;
      $display("FAIL tmo_set: err=%b sleep=%b rail1=%h rail0=%h required 1 0 96 69", err, sleep, rail1, rail0);
    end
    ko = 1'b0;
    repeat (3) @(negedge clk);
    exp_sent = exp_sent + 16'd1;
    checks++;
    if (sleep !== 1'b1 || sent_cnt !== exp_sent || err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_complete: sleep=%b cnt=%h err=%b required 1 %h 1", sleep, sent_cnt, err, exp_sent);
    end
    ko = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL tmo_sticky: err=%b busy=%b required 1 0", err, busy);
    end
  endtask

  task automatic test_reset_mid_word();
    logic quiet;
    @(negedge clk); in_data = 8'h11; in_valid = 1'b1;
    @(negedge clk); in_data = 8'h22;
    @(negedge clk); in_data = 8'h33;
    @(negedge clk); in_valid = 1'b0;
    checks++;
    if (sleep !== 1'b0 || rail1 !== 8'h11) begin
      errors++; $display("FAIL mid_data: sleep=%b rail1=%h required 0 11", sleep, rail1);
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_sent = 16'd0;
    checks++;
    if (rail1 !== 8'h00 || rail0 !== 8'h00 || sleep !== 1'b1 || in_ready !== 1'b1 ||
        sent_cnt !== 16'h0000 || err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: r1=%h r0=%h sleep=%b rdy=%b cnt=%h err=%b busy=%b required 00 00 1 1 0000 0 1",
               rail1, rail0, sleep, in_ready, sent_cnt, err, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_empty: busy=%b required 0", busy); end
    quiet = 1'b1;
    repeat (10) begin @(negedge clk); if (sleep !== 1'b1) quiet = 1'b0; end
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("FAIL mid_no_emit: sleep went %b required 1", quiet); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.sent_q = 16'hFFFE;
    @(negedge clk);
    release dut.sent_q;
    exp_sent = 16'hFFFE;
    do_word(8'h3C);
    checks++;
    if (sent_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h required FFFF", sent_cnt); end
    do_word(8'hC3);
    checks++;
    if (sent_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_0000: got %h required 0000", sent_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_reset_mid_word();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mtncl_sync_tx.md
# mtncl_sync_tx

Clocked transmitter that feeds single-rail synchronous words into an MTNCL pipeline as dual-rail DATA/NULL wavefronts. It buffers incoming words in a small FIFO, drives each word as a DATA wavefront, and sequences the return to NULL. Each phase change is paced by the downstream `ko` completion signal, which the AND/OR completion trees at the pipeline input register produce. It is the synchronous-side initiator of the same four-phase MTNCL handshake that those trees terminate.

## Interface
- `WIDTH`, 8: data bits per word; the dual-rail bus has `WIDTH` rail pairs.
- `DEPTH`, 4: FIFO entries; power of 2, ≥2.
- `TIMEOUT`, 255: maximum cycles allowed in a wait state before `err` sets; 8-bit counter.

Ports:
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset; one clock, reset is synchronous and active-high.
- `in_data` input WIDTH: word to send.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: FIFO can accept a word; equals `!full`.
- `ko` input 1: downstream completion, asynchronous to `clk`. 1 = request-for-DATA, 0 = request-for-NULL.
- `rail1` output WIDTH: dual-rail true rails.
- `rail0` output WIDTH: dual-rail false rails.
- `sleep` output 1: MTNCL sleep to the first stage; 1 forces NULL.
- `busy` output 1: state is not IDLE, or the FIFO is not empty.
- `err` output 1: sticky handshake timeout flag.
- `sent_cnt` output 16: count of completed DATA+NULL cycles; wraps at 2^16.

## Operation
- `ko` passes through a 2-flop synchronizer to give `ko_s`. Both flops reset to 0. All decisions use `ko_s` only.
- FIFO:
  - A push occurs when `in_valid && in_ready`.
  - A pop occurs only on the IDLE→DATA_WAIT transition.
  - The FIFO has no bypass path: a pushed word is poppable from the next cycle.
  - Push and pop in the same cycle are allowed when neither full nor empty. The count is then unchanged.
- FSM states: NULL_WAIT, IDLE, DATA_WAIT.
  - NULL_WAIT: `rail1`=`rail0`=0 and `sleep`=1. When `ko_s`=1, go to IDLE.
  - IDLE: bus stays NULL. When the FIFO is not empty and `ko_s`=1:
    - register the head word as `rail1`=d and `rail0`=~d;
    - set `sleep`=0;
    - pop the FIFO;
    - go to DATA_WAIT.
  - DATA_WAIT: hold DATA. When `ko_s`=0:
    - drive NULL (`rail1`=`rail0`=0, `sleep`=1);
    - increment `sent_cnt`;
    - go to NULL_WAIT.
- Rail invariant: `rail1[i] & rail0[i]` is never 1. A DATA word has exactly one rail high per bit.
- All of `rail1`, `rail0` and `sleep` are registered and change on the same edge, so no mixed DATA/NULL word appears.
- Timeout counter:
  - Clears on entry to NULL_WAIT or DATA_WAIT.
  - Increments each cycle spent in either of those states and saturates at `TIMEOUT`.
  - On reaching `TIMEOUT`, `err` sets and stays set until `rst`.
  - The FSM keeps waiting; `err` does not abort the handshake.
- IDLE with an empty FIFO does not time out.

## Timing
- Reset values:
  - `rail1`=0, `rail0`=0, `sleep`=1, `err`=0, `sent_cnt`=0, `busy`=1.
  - FIFO empty, so `in_ready`=1.
  - State is NULL_WAIT.
- Reset mid-word: the bus returns to NULL on the reset edge, and FIFO contents are discarded.
- Synchronizer latency is 2 cycles, plus 1 cycle for the FSM reaction. A `ko` edge therefore changes the outputs 3 edges later at most.
- Fill-to-send latency, with `ko_s`=1, FIFO empty and state IDLE:
  - Push at edge N makes the FIFO non-empty at N+1.
  - DATA is on the rails after edge N+1.
- Minimum handshake cycle is 3 cycles per word for the FSM with an instant `ko`. With synchronizer delay, `ko` delay adds at least 4 cycles.
- Full FIFO: `in_ready`=0, and `in_valid` is ignored. `in_ready` returns to 1 the cycle after a pop.
- A `ko_s` that stays 1 in DATA_WAIT is legal: hold DATA indefinitely and time out per the counter.
- A `ko_s`=0 in IDLE has no effect; the FSM waits for `ko_s`=1 before sending.
- `sent_cnt` wraps from 0xFFFF to 0x0000.
- `busy` is 0 only in IDLE with the FIFO empty.

## Test plan
- Reset, then tie `ko`=1: the bus holds NULL (`sleep`=1, rails 0); after 3 cycles the FSM reaches IDLE; `in_ready`=1 and `busy` falls to 0.
- Push 0xA5, with the bench modelling `ko` falling 2 cycles after DATA and rising 2 cycles after NULL:
  - DATA is `rail1`=0xA5, `rail0`=0x5A, `sleep`=0;
  - then NULL follows;
  - then `sent_cnt`=1.
- Push 5 words back-to-back (0x01 to 0x05) with `ko` held at 0:
  - `in_ready` drops after the 4th word is accepted;
  - 0x05 must be held off;
  - releasing `ko` drains the words in order 0x01 to 0x04, then 0x05.
- Hold `ko`=1 during DATA_WAIT with `TIMEOUT`=10:
  - `err` rises exactly 10 cycles after entry;
  - DATA is still held;
  - later `ko`=0 completes the word normally, and `err` stays 1.
- Assert `rst` for 1 cycle while in DATA_WAIT with 2 words queued:
  - the next cycle shows NULL, an empty FIFO, `sent_cnt`=0 and `err`=0;
  - no queued word is emitted afterwards.
- Preload `sent_cnt` to 0xFFFE and run 2 handshakes: `sent_cnt` reads 0xFFFF, then 0x0000. Check `rail1&rail0`=0 on every cycle throughout.
